// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types and defaults for the RAM port arbiter
package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    function automatic req_id_e other_id(input req_id_e id);
        return (id == REQ_CPU) ? REQ_DMA : REQ_CPU;
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// rtl/ram_arb_rr_pick.sv - 2-way round-robin picker, combinational
module ram_arb_rr_pick
    import ram_port_arbiter_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dma_req,
    input  req_id_e last_grant,
    output req_id_e grant_id,
    output logic    grant_valid
);

    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_id    = REQ_CPU;
        if (cpu_req && dma_req) begin
            // On a tie the requester served least recently wins.
            grant_id = other_id(last_grant);
        end else if (dma_req) begin
            grant_id = REQ_DMA;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one single-port RAM between CPU and DMA requesters
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int              CNT_W    = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e        state_q, state_d;
    req_id_e           last_grant_q, last_grant_d;
    req_id_e           gnt_id_q, gnt_id_d;
    logic              gnt_we_q, gnt_we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    req_id_e           pick_id;
    logic              pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    ram_arb_rr_pick u_pick (
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .last_grant  (last_grant_q),
        .grant_id    (pick_id),
        .grant_valid (pick_valid)
    );

    // Request fields are only looked at on the IDLE->ISSUE edge.
    assign sel_we    = (pick_id == REQ_DMA) ? dma_we    : cpu_we;
    assign sel_addr  = (pick_id == REQ_DMA) ? dma_addr  : cpu_addr;
    assign sel_wdata = (pick_id == REQ_DMA) ? dma_wdata : cpu_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        gnt_we_d     = gnt_we_q;
        cnt_d        = cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        cpu_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d      = ST_ISSUE;
                    last_grant_d = pick_id;
                    gnt_id_d     = pick_id;
                    gnt_we_d     = sel_we;
                    ram_addr_d   = sel_addr;
                    ram_wdata_d  = sel_wdata;
                    ram_we_d     = sel_we;
                end
            end
            ST_ISSUE: begin
                if (gnt_we_q) begin
                    state_d   = ST_DONE;
                    cpu_ack_d = (gnt_id_q == REQ_CPU);
                    dma_ack_d = (gnt_id_q == REQ_DMA);
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    if (gnt_id_q == REQ_CPU) begin
                        cpu_rdata_d = ram_rdata;
                        cpu_ack_d   = 1'b1;
                    end else begin
                        dma_rdata_d = ram_rdata;
                        dma_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                // Always pass through IDLE so a still-held req is re-arbitrated.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_DMA;
            gnt_id_q     <= REQ_CPU;
            gnt_we_q     <= 1'b0;
            cnt_q        <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            gnt_we_q     <= gnt_we_d;
            cnt_q        <= cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
